// File: rtl/mem1_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem1_lsu
// Purpose  : First memory stage. Registers the EX-to-MEM1 bus, runs the
//            data-bus request/grant/response handshake, holds the pipeline
//            through stallreq_mem1 until load data or store ack arrives,
//            packs the MEM1-to-MEM2 bus and forwards the ALU result to ID.
// Ports    : clk, rst (async, active-high), flush, stall[STALL_W-1:0]
//            ex2mem1_bus[237:0]   in  : from EX
//            mem12mem2_bus[245:0] out : to MEM2
//            mem12id_fwd[70:0]    out : to ID bypass / load-use detection
//            stallreq_mem1        out : to stall controller
//            dbus_req/we/addr/wstrb/wdata out, dbus_gnt/rvalid/rdata in
//            misalign             out : misaligned-access flag
// Config   : define MEM1_MISALIGN_CHK_EN to enable misalignment checking.
// Revision : 1.0 - initial release
// ============================================================================
module mem1_lsu #(
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic [237:0]       ex2mem1_bus,
  output logic [245:0]       mem12mem2_bus,
  output logic [70:0]        mem12id_fwd,
  output logic               stallreq_mem1,
  output logic               dbus_req,
  output logic               dbus_we,
  output logic [63:0]        dbus_addr,
  output logic [7:0]         dbus_wstrb,
  output logic [63:0]        dbus_wdata,
  input  logic               dbus_gnt,
  input  logic               dbus_rvalid,
  input  logic [63:0]        dbus_rdata,
  output logic               misalign
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e        state_q;
  logic [63:0]   rdata_q;
  logic [237:0]  pipe_q;
  logic [237:0]  pipe_d;

  // ---------------------------------------------------------------------------
  // EX-to-MEM1 pipeline register
  // ---------------------------------------------------------------------------
  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (stall[4] && !stall[5]) begin
      pipe_d = '0;
    end else if (!stall[4]) begin
      pipe_d = ex2mem1_bus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Field decode
  // ---------------------------------------------------------------------------
  logic [6:0]  w_lsu_op;
  logic        w_en, w_we, w_sz_b, w_sz_h, w_sz_w, w_sz_d;
  logic        w_sel_rf_res, w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [63:0] w_ex_result, w_store_data, w_pc;
  logic [31:0] w_inst;
  logic [2:0]  w_a;

  assign w_lsu_op     = pipe_q[237:231];
  assign w_sel_rf_res = pipe_q[230];
  assign w_rf_we      = pipe_q[229];
  assign w_rf_waddr   = pipe_q[228:224];
  assign w_ex_result  = pipe_q[223:160];
  assign w_store_data = pipe_q[159:96];
  assign w_pc         = pipe_q[95:32];
  assign w_inst       = pipe_q[31:0];

  assign w_en   = w_lsu_op[6];
  assign w_we   = w_lsu_op[5];
  assign w_sz_d = w_lsu_op[4];
  assign w_sz_w = w_lsu_op[3];
  assign w_sz_h = w_lsu_op[2];
  assign w_sz_b = w_lsu_op[1];
  assign w_a    = w_ex_result[2:0];

  // The signedness bit is consumed in MEM2; MEM1 only passes it through.
  logic w_unused;
  assign w_unused = ^{stall, w_lsu_op[0]};

  // ---------------------------------------------------------------------------
  // Misalignment check
  // ---------------------------------------------------------------------------
  logic w_misalign;
`ifdef MEM1_MISALIGN_CHK_EN
  assign w_misalign = w_en & ((w_sz_h & w_a[0]) |
                              (w_sz_w & (w_a[1:0] != 2'b00)) |
                              (w_sz_d & (w_a != 3'b000)));
`else
  assign w_misalign = 1'b0;
`endif

  // A misaligned access is treated as if no memory op were present.
  logic w_mem_en;
  assign w_mem_en = w_en & ~w_misalign;

  // ---------------------------------------------------------------------------
  // Byte lanes and store data
  // ---------------------------------------------------------------------------
  logic [7:0]  w_ram_sel;
  logic [63:0] w_wdata;

  always_comb begin
    w_ram_sel = 8'h00;
    if (w_mem_en) begin
      if (w_sz_d)      w_ram_sel = 8'hFF;
      else if (w_sz_w) w_ram_sel = 8'h0F << w_a;
      else if (w_sz_h) w_ram_sel = 8'h03 << w_a;
      else if (w_sz_b) w_ram_sel = 8'h01 << w_a;
    end
  end

  always_comb begin
    w_wdata = w_store_data;
    if (w_sz_b)      w_wdata = {8{w_store_data[7:0]}};
    else if (w_sz_h) w_wdata = {4{w_store_data[15:0]}};
    else if (w_sz_w) w_wdata = {2{w_store_data[31:0]}};
  end

  // ---------------------------------------------------------------------------
  // Bus handshake FSM
  // ---------------------------------------------------------------------------
  logic w_dbus_req;
  assign w_dbus_req = w_mem_en & (state_q == S_IDLE) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_dbus_req && dbus_gnt) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            // A response arriving with the flush closes the transaction;
            // otherwise the in-flight response still has to be absorbed.
            state_q <= dbus_rvalid ? S_IDLE : S_DRAIN;
          end else if (dbus_rvalid) begin
            if (stall[4]) begin
              state_q <= S_DONE;
              rdata_q <= dbus_rdata;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          if (flush || !stall[4]) state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (dbus_rvalid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [63:0] w_mem_rdata;
  always_comb begin
    w_mem_rdata = '0;
    if (state_q == S_DONE)                     w_mem_rdata = rdata_q;
    else if (state_q == S_WAIT && dbus_rvalid) w_mem_rdata = dbus_rdata;
  end

  logic [6:0] w_out_lsu_op;
  logic       w_out_rf_we;
  assign w_out_lsu_op = w_misalign ? 7'd0 : w_lsu_op;
  assign w_out_rf_we  = w_rf_we & ~w_misalign;

  assign stallreq_mem1 = w_mem_en &
                         ~((state_q == S_DONE) | ((state_q == S_WAIT) & dbus_rvalid));

  assign dbus_req   = w_dbus_req;
  assign dbus_we    = w_mem_en & w_we;
  assign dbus_addr  = {w_ex_result[63:3], 3'b000};
  assign dbus_wstrb = w_we ? w_ram_sel : 8'h00;
  assign dbus_wdata = w_wdata;
  assign misalign   = w_misalign;

  assign mem12mem2_bus = {w_mem_rdata, w_out_lsu_op, w_ram_sel, w_sel_rf_res,
                          w_out_rf_we, w_rf_waddr, w_ex_result, w_pc, w_inst};
  assign mem12id_fwd   = {w_sel_rf_res, w_out_rf_we, w_rf_waddr, w_ex_result};

endmodule
`default_nettype wire

// File: tb/tb_mem1_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem1_lsu
// Purpose  : Directed self-checking bench for mem1_lsu. Inputs change on the
//            falling edge; outputs are sampled 1 time unit later.
// Config   : honours MEM1_MISALIGN_CHK_EN for the misaligned-halfword case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem1_lsu;

  localparam logic [6:0] OP_LW = 7'b1001000;
  localparam logic [6:0] OP_LD = 7'b1010000;
  localparam logic [6:0] OP_SB = 7'b1100010;
  localparam logic [6:0] OP_SW = 7'b1101000;
  localparam logic [6:0] OP_LH = 7'b1000100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [5:0]   ext_stall = 6'd0;
  logic [5:0]   stall;
  logic [237:0] ex2mem1_bus = '0;
  logic [245:0] mem12mem2_bus;
  logic [70:0]  mem12id_fwd;
  logic         stallreq_mem1;
  logic         dbus_req, dbus_we;
  logic [63:0]  dbus_addr, dbus_wdata;
  logic [7:0]   dbus_wstrb;
  logic         dbus_gnt = 1'b0;
  logic         dbus_rvalid = 1'b0;
  logic [63:0]  dbus_rdata = '0;
  logic         misalign;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_base  = 0;

  // Stall controller model: a MEM1 request freezes MEM1 and MEM2 together.
  assign stall = {6{stallreq_mem1}} | ext_stall;

  mem1_lsu #(.STALL_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .stall         (stall),
    .ex2mem1_bus   (ex2mem1_bus),
    .mem12mem2_bus (mem12mem2_bus),
    .mem12id_fwd   (mem12id_fwd),
    .stallreq_mem1 (stallreq_mem1),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_wstrb    (dbus_wstrb),
    .dbus_wdata    (dbus_wdata),
    .dbus_gnt      (dbus_gnt),
    .dbus_rvalid   (dbus_rvalid),
    .dbus_rdata    (dbus_rdata),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && dbus_req && dbus_gnt) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [237:0] mk(input logic [6:0] op, input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [63:0] res,
                                      input logic [63:0] sd);
    return {op, sel, we, wa, res, sd, 64'h0000_0000_8000_0000, 32'h0000_0013};
  endfunction

  function automatic logic [63:0] f_rdata();
    return mem12mem2_bus[245:182];
  endfunction
  function automatic logic [63:0] f_sel();
    return 64'(mem12mem2_bus[174:167]);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    repeat (3) cyc();
    #1;
    check_val("rst_mem2_lo", mem12mem2_bus[63:0], 64'd0);
    check_val("rst_mem2_rd", f_rdata(), 64'd0);
    check_val("rst_fwd", mem12id_fwd[63:0], 64'd0);
    check_val("rst_ctl", 64'({stallreq_mem1, dbus_req, dbus_we, dbus_wstrb, misalign}), 64'd0);
    cyc();
    rst = 1'b0;

    // ---------------- lw @0x1004, gnt same cycle ----------------
    hs_base = hs_cnt;
    ex2mem1_bus = mk(OP_LW, 1'b1, 1'b1, 5'd3, 64'h1004, 64'd0);
    cyc();
    ex2mem1_bus = '0;
    dbus_gnt = 1'b1;
    #1;
    check_val("lw_req", 64'(dbus_req), 64'd1);
    check_val("lw_addr", dbus_addr, 64'h1000);
    check_val("lw_sel", f_sel(), 64'hF0);
    check_val("lw_strb", 64'(dbus_wstrb), 64'd0);
    check_val("lw_stallreq0", 64'(stallreq_mem1), 64'd1);
    check_val("lw_fwd", mem12id_fwd[63:0], 64'h1004);
    check_val("lw_fwd_ctl", 64'(mem12id_fwd[70:64]), 64'({1'b1, 1'b1, 5'd3}));
    cyc();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 64'h1122_3344_5566_7788;
    #1;
    check_val("lw_stallreq1", 64'(stallreq_mem1), 64'd0);
    check_val("lw_req_wait", 64'(dbus_req), 64'd0);
    check_val("lw_rdata", f_rdata(), 64'h1122_3344_5566_7788);
    cyc();
    // Stray response while idle must be ignored.
    dbus_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check_val("idle_rv_rdata", f_rdata(), 64'd0);
    check_val("idle_rv_stall", 64'(stallreq_mem1), 64'd0);
    check_val("lw_hs", 64'(hs_cnt - hs_base), 64'd1);
    dbus_rvalid = 1'b0;

    // ---------------- sb 0xAB @0x2003 ----------------
    cyc();
    hs_base = hs_cnt;
    ex2mem1_bus = mk(OP_SB, 1'b0, 1'b0, 5'd0, 64'h2003, 64'h12AB);
    cyc();
    ex2mem1_bus = '0;
    dbus_gnt = 1'b1;
    #1;
    check_val("sb_we", 64'(dbus_we), 64'd1);
    check_val("sb_strb", 64'(dbus_wstrb), 64'h08);
    check_val("sb_wdata", dbus_wdata, 64'hABAB_ABAB_ABAB_ABAB);
    check_val("sb_addr", dbus_addr, 64'h2000);
    check_val("sb_stall0", 64'(stallreq_mem1), 64'd1);
    cyc();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = '0;
    #1;
    check_val("sb_stall_ack", 64'(stallreq_mem1), 64'd0);
    cyc();
    dbus_rvalid = 1'b0;
    #1;
    check_val("sb_hs", 64'(hs_cnt - hs_base), 64'd1);

    // ---------------- sw @0x4004, gnt withheld 3 cycles ----------------
    cyc();
    hs_base = hs_cnt;
    ex2mem1_bus = mk(OP_SW, 1'b0, 1'b0, 5'd0, 64'h4004, 64'h1234_5678_DEAD_BEEF);
    cyc();
    // A different op waits upstream; MEM1 must stay frozen on the store.
    ex2mem1_bus = mk(OP_LD, 1'b1, 1'b1, 5'd9, 64'h9998, 64'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("hold_req", 64'(dbus_req), 64'd1);
      check_val("hold_addr", dbus_addr, 64'h4000);
      check_val("hold_wdata", dbus_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
      check_val("hold_strb", 64'(dbus_wstrb), 64'hF0);
      check_val("hold_stall", 64'(stallreq_mem1), 64'd1);
      cyc();
    end
    dbus_gnt = 1'b1;
    #1;
    check_val("hold_req_gnt", 64'(dbus_req), 64'd1);
    check_val("hold_addr_gnt", dbus_addr, 64'h4000);
    cyc();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1;
    ex2mem1_bus = '0;
    #1;
    check_val("hold_req_wait", 64'(dbus_req), 64'd0);
    check_val("hold_stall_ack", 64'(stallreq_mem1), 64'd0);
    cyc();
    dbus_rvalid = 1'b0;
    #1;
    check_val("hold_hs", 64'(hs_cnt - hs_base), 64'd1);
    check_val("hold_fwd_clr", mem12id_fwd[63:0], 64'd0);

    // ---------------- rvalid under external stall -> DONE ----------------
    cyc();
    hs_base = hs_cnt;
    ex2mem1_bus = mk(OP_LW, 1'b1, 1'b1, 5'd5, 64'h5000, 64'd0);
    cyc();
    ex2mem1_bus = '0;
    dbus_gnt = 1'b1;
    #1;
    check_val("done_req", 64'(dbus_req), 64'd1);
    cyc();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 64'hCAFE_F00D_0BAD_BEEF;
    ext_stall = 6'b110000;
    #1;
    check_val("done_bypass", f_rdata(), 64'hCAFE_F00D_0BAD_BEEF);
    check_val("done_stall_rv", 64'(stallreq_mem1), 64'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      dbus_rvalid = 1'b0;
      dbus_rdata = 64'h5555_5555_5555_5555;
      #1;
      check_val("done_hold_rd", f_rdata(), 64'hCAFE_F00D_0BAD_BEEF);
      check_val("done_hold_req", 64'(dbus_req), 64'd0);
      check_val("done_hold_stall", 64'(stallreq_mem1), 64'd0);
    end
    cyc();
    ext_stall = 6'd0;
    #1;
    check_val("done_release_rd", f_rdata(), 64'hCAFE_F00D_0BAD_BEEF);
    cyc();
    #1;
    check_val("done_after_req", 64'(dbus_req), 64'd0);
    check_val("done_after_fwd", mem12id_fwd[63:0], 64'd0);
    check_val("done_hs", 64'(hs_cnt - hs_base), 64'd1);

    // ---------------- flush in WAIT, then new ld ----------------
    cyc();
    hs_base = hs_cnt;
    ex2mem1_bus = mk(OP_LD, 1'b1, 1'b1, 5'd6, 64'h6000, 64'd0);
    cyc();
    ex2mem1_bus = '0;
    dbus_gnt = 1'b1;
    #1;
    check_val("fl_req", 64'(dbus_req), 64'd1);
    cyc();
    dbus_gnt = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    ex2mem1_bus = mk(OP_LD, 1'b1, 1'b1, 5'd7, 64'h7000, 64'd0);
    #1;
    check_val("fl_fwd_clr", mem12id_fwd[63:0], 64'd0);
    check_val("fl_drain_req", 64'(dbus_req), 64'd0);
    cyc();
    ex2mem1_bus = '0;
    dbus_gnt = 1'b1;
    #1;
    check_val("fl_new_addr", dbus_addr, 64'h7000);
    check_val("fl_drain_req2", 64'(dbus_req), 64'd0);
    check_val("fl_drain_stall", 64'(stallreq_mem1), 64'd1);
    cyc();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    check_val("fl_stale_rd", f_rdata(), 64'd0);
    check_val("fl_stale_stall", 64'(stallreq_mem1), 64'd1);
    cyc();
    dbus_rvalid = 1'b0;
    dbus_gnt = 1'b1;
    #1;
    check_val("fl_new_req", 64'(dbus_req), 64'd1);
    check_val("fl_new_sel", f_sel(), 64'hFF);
    cyc();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 64'h0102_0304_0506_0708;
    #1;
    check_val("fl_new_rd", f_rdata(), 64'h0102_0304_0506_0708);
    check_val("fl_new_stall", 64'(stallreq_mem1), 64'd0);
    cyc();
    dbus_rvalid = 1'b0;
    #1;
    check_val("fl_hs", 64'(hs_cnt - hs_base), 64'd2);

    // ---------------- flush together with gnt ----------------
    cyc();
    hs_base = hs_cnt;
    ex2mem1_bus = mk(OP_LW, 1'b1, 1'b1, 5'd8, 64'h8000, 64'd0);
    cyc();
    ex2mem1_bus = '0;
    flush = 1'b1;
    dbus_gnt = 1'b1;
    #1;
    check_val("flg_req", 64'(dbus_req), 64'd0);
    cyc();
    flush = 1'b0;
    dbus_gnt = 1'b0;
    #1;
    check_val("flg_hs", 64'(hs_cnt - hs_base), 64'd0);
    check_val("flg_fwd", mem12id_fwd[63:0], 64'd0);

    // ---------------- non-memory op and bubble ----------------
    cyc();
    ex2mem1_bus = mk(7'd0, 1'b0, 1'b1, 5'd7, 64'hCAFE, 64'd0);
    cyc();
    ex2mem1_bus = mk(7'd0, 1'b0, 1'b1, 5'd9, 64'hBEEF, 64'd0);
    ext_stall = 6'b010000;
    #1;
    check_val("alu_fwd", mem12id_fwd[63:0], 64'hCAFE);
    check_val("alu_fwd_ctl", 64'(mem12id_fwd[70:64]), 64'({1'b0, 1'b1, 5'd7}));
    check_val("alu_ctl", 64'({stallreq_mem1, dbus_req}), 64'd0);
    cyc();
    ext_stall = 6'd0;
    #1;
    check_val("bubble_fwd", 64'(mem12id_fwd[70:64]), 64'd0);
    cyc();
    ex2mem1_bus = '0;
    #1;
    check_val("alu2_fwd", mem12id_fwd[63:0], 64'hBEEF);

    // ---------------- lh @0x3001 ----------------
    cyc();
    ex2mem1_bus = mk(OP_LH, 1'b1, 1'b1, 5'd4, 64'h3001, 64'd0);
    cyc();
    ex2mem1_bus = '0;
`ifdef MEM1_MISALIGN_CHK_EN
    dbus_gnt = 1'b1;
    #1;
    check_val("mis_flag", 64'(misalign), 64'd1);
    check_val("mis_req", 64'(dbus_req), 64'd0);
    check_val("mis_stall", 64'(stallreq_mem1), 64'd0);
    check_val("mis_rfwe", 64'(mem12mem2_bus[165]), 64'd0);
    check_val("mis_op", 64'(mem12mem2_bus[181:175]), 64'd0);
    check_val("mis_fwd_we", 64'(mem12id_fwd[69]), 64'd0);
    cyc();
    dbus_gnt = 1'b0;
    #1;
    check_val("mis_gone", 64'(misalign), 64'd0);
`else
    dbus_gnt = 1'b1;
    #1;
    check_val("lh_flag", 64'(misalign), 64'd0);
    check_val("lh_req", 64'(dbus_req), 64'd1);
    check_val("lh_sel", f_sel(), 64'h06);
    check_val("lh_rfwe", 64'(mem12mem2_bus[165]), 64'd1);
    cyc();
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 64'h0000_0000_0000_AA55;
    #1;
    check_val("lh_rd", f_rdata(), 64'h0000_0000_0000_AA55);
    cyc();
    dbus_rvalid = 1'b0;
`endif

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
